// File: rtl/subtree_arb_pkg.sv
// subtree_arb_pkg: shared types, defaults and width helper for the subtree round-robin arbiter
//   arb_state_e  : arbiter FSM states
//   N_REQ_DEF    : default requester count (one per child instance)
//   MAX_HOLD_DEF : default maximum consecutive grant cycles
//   idx_w(n)     : index width needed to address n items
package subtree_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF    = 15;
    localparam int MAX_HOLD_DEF = 16;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating priority encoder
//   eligible : candidate bit vector
//   ptr      : highest-priority position; search runs ptr, ptr+1, ..., N-1, 0, ...
//   found    : any eligible bit set
//   idx      : first eligible position at or after ptr (with wrap); 0 when none
module rr_pick
    import subtree_arb_pkg::*;
#(
    parameter int N = N_REQ_DEF
) (
    input  logic [N-1:0]          eligible,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic                  found,
    output logic [idx_w(N)-1:0]   idx
);

    localparam int IW = idx_w(N);
    localparam int CW = IW + 1;

    logic [CW-1:0] c;

    // Walk offsets from farthest to nearest so the nearest eligible
    // position (smallest rotation from ptr) is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = {1'b0, ptr} + CW'(i);
            c = (c >= CW'(N)) ? c - CW'(N) : c;
            if (eligible[c[IW-1:0]]) begin
                found = 1'b1;
                idx   = c[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/subtree_rr_arbiter.sv
// subtree_rr_arbiter: fair round-robin arbiter with bounded hold and timeout lockout for sibling leaves
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset
//   req_i         : per-leaf level request
//   grant_o       : registered one-hot grant, zero when idle
//   grant_valid_o : OR of grant_o
//   grant_idx_o   : current owner index, 0 when idle
//   timeout_o     : one-cycle pulse when an ownership is force-revoked
//   masked_o      : requesters locked out after a timeout until they drop their request
module subtree_rr_arbiter
    import subtree_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      grant_valid_o,
    output logic [idx_w(N_REQ)-1:0]   grant_idx_o,
    output logic                      timeout_o,
    output logic [N_REQ-1:0]          masked_o
);

    localparam int IW = idx_w(N_REQ);
    localparam int HW = idx_w(MAX_HOLD);

    arb_state_e       state_q, state_n;
    logic [IW-1:0]    owner_q, owner_n;
    logic [IW-1:0]    ptr_q, ptr_n;
    logic [IW-1:0]    pick_idx;
    logic [HW-1:0]    hold_q, hold_n;
    logic [N_REQ-1:0] eligible, mask_n;
    logic             pick_found, owner_req, at_limit, timeout_n;

    // masked_o doubles as the lockout mask register.
    assign eligible  = req_i & ~masked_o;
    assign owner_req = req_i[owner_q];
    assign at_limit  = hold_q == HW'(MAX_HOLD - 1);

    rr_pick #(.N(N_REQ)) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        state_n   = state_q;
        owner_n   = owner_q;
        ptr_n     = ptr_q;
        hold_n    = hold_q;
        timeout_n = 1'b0;
        mask_n    = masked_o & req_i;
        if (state_q == IDLE) begin
            if (pick_found) begin
                state_n = GRANT;
                owner_n = pick_idx;
                hold_n  = '0;
            end
        end else if (!owner_req || at_limit) begin
            // A drop on the last allowed cycle is a normal release, not a timeout.
            state_n = IDLE;
            ptr_n   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
            if (owner_req) begin
                timeout_n       = 1'b1;
                mask_n[owner_q] = 1'b1;
            end
        end else begin
            hold_n = hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            ptr_q         <= '0;
            hold_q        <= '0;
            grant_o       <= '0;
            grant_valid_o <= 1'b0;
            grant_idx_o   <= '0;
            timeout_o     <= 1'b0;
            masked_o      <= '0;
        end else begin
            state_q       <= state_n;
            owner_q       <= owner_n;
            ptr_q         <= ptr_n;
            hold_q        <= hold_n;
            grant_o       <= (state_n == GRANT) ? (N_REQ'(1) << owner_n) : '0;
            grant_valid_o <= state_n == GRANT;
            grant_idx_o   <= (state_n == GRANT) ? owner_n : '0;
            timeout_o     <= timeout_n;
            masked_o      <= mask_n;
        end
    end

endmodule
